modn_step_counter: RTL

Parametrised modulo-N up/down counter that generalises the fixed 4-bit mod-N counter. It adds configurable width and modulus, a variable step size, an enable, and a synchronous parallel load. A compile-time wrap/saturate mode is included, along with registered wrap/saturate event pulses. It is intended as the shared timebase/index counter for sequential blocks such as prescalers, ring-buffer pointers and PWM period generators.

---
 rtl/modn_step_counter_if.sv | 29 ++
 rtl/modn_step_counter.sv | 91 +++++++++
 2 files changed

// File: rtl/modn_step_counter_if.sv
// Port bundle for modn_step_counter: control inputs from the user (master),
// registered count and event flags back from the counter (slave).
interface modn_step_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  // No valid/ready handshake: every input is sampled on each rising clk edge
  // and the counter never back-pressures. Outputs are valid every cycle.
  logic              en;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic              sat;
  logic              at_max;
  logic              at_zero;

  modport master (
    output en, up_down, step, load, load_val,
    input  count, wrap, sat, at_max, at_zero
  );

  modport slave (
    input  en, up_down, step, load, load_val,
    output count, wrap, sat, at_max, at_zero
  );
endinterface

// File: rtl/modn_step_counter.sv
// Parametrised modulo-N up/down counter with variable step, parallel load,
// and either wrap-around or clamp-at-limit behaviour with registered event pulses.
module modn_step_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 200,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               rst,
  modn_step_counter_if.slave bus
);
  localparam int W1 = WIDTH + 1;
  localparam int SW = (STEP_W > W1) ? STEP_W : W1;
  localparam logic [W1-1:0]    MOD_C = W1'(MODULUS);
  localparam logic [W1-1:0]    MAX_C = W1'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MODULUS - 1);
  localparam logic [SW-1:0]    MAX_S = SW'(MODULUS - 1);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("modn_step_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [SW-1:0] step_w;
  logic [W1-1:0] s;
  logic [W1-1:0] cnt_x;
  logic [W1-1:0] lv_x;
  logic [W1-1:0] sum;

  always_comb begin
    step_w  = SW'(bus.step);
    s       = (step_w > MAX_S) ? W1'(MAX_S) : W1'(step_w);
    cnt_x   = {1'b0, count_q};
    lv_x    = {1'b0, bus.load_val};
    sum     = cnt_x + s;
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;

    if (bus.load) begin
      count_d = (lv_x > MAX_C) ? MAX_N : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (sum < MOD_C) begin
          count_d = WIDTH'(sum);
        end else if (SATURATE != 0) begin
          count_d = MAX_N;
          sat_d   = 1'b1;
        end else begin
          count_d = WIDTH'(sum - MOD_C);
          wrap_d  = 1'b1;
        end
      end else begin
        if (cnt_x >= s) begin
          count_d = WIDTH'(cnt_x - s);
        end else if (SATURATE != 0) begin
          count_d = '0;
          sat_d   = 1'b1;
        end else begin
          // cnt_x + MOD_C < 2*MODULUS <= 2**(WIDTH+1), so this cannot overflow
          count_d = WIDTH'(cnt_x + MOD_C - s);
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.sat     = sat_q;
  assign bus.at_max  = (count_q == MAX_N);
  assign bus.at_zero = (count_q == '0);
endmodule
